// File: rtl/softplus_pkg.sv
// softplus_pkg: Q8.8 format constants and id-width helper shared by the softplus scheduler files.
package softplus_pkg;
   localparam int SP_DATA_W = 16;
   localparam int SP_FRAC_W = 8;
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; lowest requesting index at or after ptr_i wins.
module rr_arbiter
   import softplus_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]        req_i,
   input  logic [id_w(N_REQ)-1:0]  ptr_i,
   output logic [N_REQ-1:0]        gnt_o
);
   logic [N_REQ-1:0] rot_req, rot_gnt;
   always_comb begin
      rot_req = N_REQ'({req_i, req_i} >> ptr_i);
      rot_gnt = rot_req & (-rot_req);
      gnt_o   = N_REQ'(({rot_gnt, rot_gnt} << ptr_i) >> N_REQ);
   end
endmodule

// File: rtl/softplus_core.sv
// softplus_core: combinational Q8.8 softplus, max(x,0) + ln(1+exp(-|x|)).
// The correction term is a two-segment linear fit that reaches zero at |x| = 5.
module softplus_core
   import softplus_pkg::*;
#(
   parameter int DATA_W = SP_DATA_W
) (
   input  logic [DATA_W-1:0] op_i,
   output logic [DATA_W-1:0] res_o
);
   localparam logic [DATA_W:0] K0   = (DATA_W+1)'(11 << (SP_FRAC_W - 4));
   localparam logic [DATA_W:0] BRK1 = (DATA_W+1)'(2 << SP_FRAC_W);
   localparam logic [DATA_W:0] BRK2 = (DATA_W+1)'(5 << SP_FRAC_W);
   logic [DATA_W:0]   mag;
   logic [DATA_W-1:0] tail, pos;
   always_comb begin
      mag   = op_i[DATA_W-1] ? -{op_i[DATA_W-1], op_i} : {1'b0, op_i};
      tail  = (mag < BRK1) ? DATA_W'(K0 - (mag >> 2)) :
              (mag < BRK2) ? DATA_W'((BRK2 - mag) >> 4) : '0;
      pos   = op_i[DATA_W-1] ? '0 : op_i;
      res_o = pos + tail;
   end
endmodule

// File: rtl/softplus_sched.sv
// softplus_sched: round-robin scheduler sharing one softplus core across N_REQ requesters.
// Two-stage pipeline; per-requester response counters only when SOFTPLUS_PERF_CNT_EN is defined.
module softplus_sched
   import softplus_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = SP_DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_data,
   output logic [id_w(N_REQ)-1:0]   rsp_id,
   output logic                     busy,
   input  logic                     cnt_clr,
   output logic [N_REQ*CNT_W-1:0]   perf_cnt
);
   localparam int IW = id_w(N_REQ);
   logic [N_REQ-1:0]  gnt;
   logic [IW-1:0]     p_q, p_d, g_idx, s1_id_q, rsp_id_q;
   logic [DATA_W-1:0] op_sel, s1_op_q, core_res, rsp_data_q;
   logic              s1_v_q, rsp_valid_q, s2_load, s1_free, acc;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (.req_i(req_valid), .ptr_i(p_q), .gnt_o(gnt));
   softplus_core #(.DATA_W(DATA_W)) u_core (.op_i(s1_op_q), .res_o(core_res));

   // rst_n gates req_ready so nothing is offered while reset is held
   always_comb begin
      s2_load   = s1_v_q & (~rsp_valid_q | rsp_ready);
      s1_free   = ~s1_v_q | s2_load;
      req_ready = (rst_n & s1_free) ? gnt : '0;
      acc       = |(req_valid & req_ready);
      g_idx     = '0;
      op_sel    = '0;
      for (int i = 0; i < N_REQ; i++) if (gnt[i]) begin
         g_idx  = g_idx | IW'(i);
         op_sel = op_sel | req_data[i*DATA_W +: DATA_W];
      end
      p_d = !acc ? p_q : (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + IW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q         <= '0;
         s1_v_q      <= 1'b0;
         s1_op_q     <= '0;
         s1_id_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         p_q <= p_d;
         if (s1_free) s1_v_q <= acc;
         if (acc) begin
            s1_op_q <= op_sel;
            s1_id_q <= g_idx;
         end
         if (s2_load) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= core_res;
            rsp_id_q    <= s1_id_q;
         end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = s1_v_q | rsp_valid_q;

`ifdef SOFTPLUS_PERF_CNT_EN
   logic [N_REQ-1:0][CNT_W-1:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else for (int i = 0; i < N_REQ; i++)
         if (cnt_clr) cnt_q[i] <= '0;
         else if (rsp_valid_q && rsp_ready && rsp_id_q == IW'(i) && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
   end
   assign perf_cnt = cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign perf_cnt       = '0;
`endif
endmodule

// File: tb/tb_softplus_sched.sv
// tb_softplus_sched: directed checks of arbitration, pipeline timing, backpressure, reset and counters.
// Counter saturation/clear checks run only when SOFTPLUS_PERF_CNT_EN is defined.
module tb_softplus_sched;
   localparam int N = 4, DW = 16, CW = 16;
   logic            clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0, cnt_clr = 1'b0;
   logic            rsp_valid, busy;
   logic [N-1:0]    req_valid = '0, req_ready;
   logic [N*DW-1:0] req_data = '0;
   logic [DW-1:0]   rsp_data, ref_res;
   logic [DW-1:0]   ref_op = '0;
   logic [1:0]      rsp_id;
   logic [N*CW-1:0] perf_cnt;
   logic [DW-1:0]   ops   [4] = '{16'h0100, 16'hFF00, 16'h0300, 16'hFE00};
   logic [DW-1:0]   exp_a [4] = '{16'h0170, 16'h0070, 16'h0320, 16'h0030};
   int              checks = 0, errors = 0;

   softplus_sched #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .cnt_clr(cnt_clr),
      .perf_cnt(perf_cnt));

   softplus_core #(.DATA_W(DW)) ref_core (.op_i(ref_op), .res_o(ref_res));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endtask

   task automatic pulse_rst();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      req_valid = 4'b1111;
      tick();
      tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_perf_cnt", perf_cnt, 0);
      req_valid = '0;
      rst_n     = 1'b1;
      // single operand, two-cycle latency
      rsp_ready = 1'b1;
      set_op(0, 16'h0000);
      req_valid = 4'b0001;
      #1;
      chk("t1_req_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      chk("t1_lat1_rsp_valid", rsp_valid, 0);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_id", rsp_id, 0);
      chk("t1_rsp_vs_core", rsp_data, ref_res);
      chk("t1_rsp_data", rsp_data, 16'h00B0);
      tick();
      chk("t1_drain_valid", rsp_valid, 0);
      chk("t1_drain_busy", busy, 0);
      // all four requesters streaming
      pulse_rst();
      for (int i = 0; i < N; i++) set_op(i, ops[i]);
      req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         if (c == 6) req_valid = '0;
         if (c >= 2) begin
            chk("t2_rsp_valid", rsp_valid, 1);
            chk("t2_rsp_id", rsp_id, (c - 2) % 4);
            chk("t2_rsp_data", rsp_data, exp_a[(c - 2) % 4]);
         end
         #1;
         if (c < 6) chk("t2_grant", req_ready, 1 << (c % 4));
         tick();
      end
      chk("t2_empty", rsp_valid, 0);
      // both stages full under backpressure
      rsp_ready = 1'b0;
      set_op(1, 16'h0100);
      req_valid = 4'b0010;
      #1;
      chk("t3_grant_a", req_ready, 4'b0010);
      tick();
      set_op(3, 16'h0300);
      req_valid = 4'b1000;
      #1;
      chk("t3_grant_b", req_ready, 4'b1000);
      tick();
      req_valid = 4'b0001;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk("t3_stall_req_ready", req_ready, 0);
         chk("t3_stall_valid", rsp_valid, 1);
         chk("t3_stall_id", rsp_id, 1);
         chk("t3_stall_data", rsp_data, 16'h0170);
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      chk("t3_first_id", rsp_id, 1);
      tick();
      chk("t3_second_valid", rsp_valid, 1);
      chk("t3_second_id", rsp_id, 3);
      chk("t3_second_data", rsp_data, 16'h0320);
      tick();
      chk("t3_empty", rsp_valid, 0);
      // +5.0 from requester 1 and -5.0 from requester 3, other operands garbage
      set_op(0, 16'hAAAA);
      set_op(1, 16'h0500);
      set_op(2, 16'h5555);
      set_op(3, 16'hFB00);
      req_valid = 4'b1010;
      #1;
      chk("t4_grant_1", req_ready, 4'b0010);
      tick();
      chk("t4_grant_3", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      ref_op    = 16'h0500;
      #1;
      chk("t4_rsp1_id", rsp_id, 1);
      chk("t4_rsp1_vs_core", rsp_data, ref_res);
      chk("t4_rsp1_data", rsp_data, 16'h0500);
      tick();
      ref_op = 16'hFB00;
      #1;
      chk("t4_rsp3_valid", rsp_valid, 1);
      chk("t4_rsp3_id", rsp_id, 3);
      chk("t4_rsp3_vs_core", rsp_data, ref_res);
      chk("t4_rsp3_data", rsp_data, 16'h0000);
      tick();
      for (int i = 0; i < N; i++) set_op(i, 16'h7FFF);
      tick();
      tick();
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_valid", rsp_valid, 0);
      // reset with both stages full
      rsp_ready = 1'b0;
      set_op(2, 16'hFF00);
      req_valid = 4'b0100;
      tick();
      tick();
      req_valid = 4'b1100;
      set_op(2, 16'h0300);
      #1;
      chk("t5_full_busy", busy, 1);
      chk("t5_full_valid", rsp_valid, 1);
      chk("t5_full_ready", req_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", rsp_valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_ready", req_ready, 0);
      tick();
      chk("t5_rst_hold_valid", rsp_valid, 0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("t5_first_grant", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      chk("t5_no_stale", rsp_valid, 0);
      tick();
      chk("t5_new_valid", rsp_valid, 1);
      chk("t5_new_id", rsp_id, 2);
      chk("t5_new_data", rsp_data, 16'h0320);
      tick();
      chk("t5_empty", rsp_valid, 0);
`ifdef SOFTPLUS_PERF_CNT_EN
      pulse_rst();
      set_op(2, 16'h0100);
      req_valid = 4'b0100;
      repeat (3) tick();
      req_valid = '0;
      repeat (3) tick();
      chk("t6_cnt2", perf_cnt[2*CW +: CW], 3);
      chk("t6_cnt0", perf_cnt[0 +: CW], 0);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("t6_clr", perf_cnt[2*CW +: CW], 0);
      req_valid = 4'b0001;
      repeat (65540) tick();
      chk("t6_sat", perf_cnt[0 +: CW], 16'hFFFF);
      tick();
      chk("t6_sat_hold", perf_cnt[0 +: CW], 16'hFFFF);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("t6_clr_over_inc", perf_cnt[0 +: CW], 0);
      tick();
      chk("t6_resume", perf_cnt[0 +: CW], 1);
      req_valid = '0;
      repeat (3) tick();
`else
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("t6_cnt_tied", perf_cnt, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/softplus_sched.md
SOFTPLUS_SCHED -- requirements
Module: softplus_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one softplus core (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, operand/result width, Q8.8 two's complement.
REQ-003 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester operand valid.
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 SHALL have port req_data  input  N_REQ*DATA_W  operands; requester i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port rsp_valid  output  1  result valid.
REQ-010 SHALL have port rsp_ready  input  1  downstream accept.
REQ-011 SHALL have port rsp_data  output  DATA_W  softplus result.
REQ-012 SHALL have port rsp_id  output  clog2(N_REQ)  index of the requester that issued the result.
REQ-013 SHALL have port busy  output  1  high while either pipeline stage holds valid data.
REQ-014 SHALL have port cnt_clr  input  1  synchronous clear of performance counters.
REQ-015 SHALL have port perf_cnt  output  N_REQ*CNT_W  completed-response count per requester.

Function
REQ-016 SHALL arbitrate round-robin: search starts at pointer p; lowest index at or after p (modulo N_REQ) with req_valid high wins.
REQ-017 SHALL set p to (g+1) mod N_REQ only on a transfer (req_valid[g] & req_ready[g]); p unchanged otherwise.
REQ-018 SHALL raise req_ready[g] only for the winner and only when stage 1 can load: s1 empty, or s1 moving to s2 this cycle.
REQ-019 SHALL register the accepted operand and id into stage 1 (s1_v, s1_op, s1_id).
REQ-020 SHALL drive s1_op into one combinational softplus core; its output plus s1_id load stage 2 (rsp_valid, rsp_data, rsp_id).
REQ-021 SHALL load stage 2 when s1_v and (!rsp_valid or rsp_ready).
REQ-022 SHALL give latency 2 cycles: operand accepted at edge k yields rsp_valid at edge k+2 when rsp_ready is held high.
REQ-023 SHALL sustain one accept and one response per cycle when rsp_ready is continuously high.
REQ-024 SHALL hold rsp_valid, rsp_data and rsp_id stable while rsp_valid & !rsp_ready.
REQ-025 SHALL deliver responses in accept order; no drop or duplicate under any backpressure pattern.
REQ-026 SHALL, when both stages are full and rsp_ready is low, drive req_ready all zero.
REQ-027 SHALL accept a new operand in the same cycle that stage 2 drains and stage 1 advances.
REQ-028 SHALL ignore req_data of non-granted requesters; operand bits of idle cycles have no effect.

Reset
REQ-029 SHALL on rst_n low immediately clear s1_v, rsp_valid, busy and req_ready; set p=0, rsp_data=0, rsp_id=0, s1_op=0, s1_id=0, all counters 0.
REQ-030 SHALL discard in-flight operands when reset asserts mid-stream; the first grant after release goes to the lowest valid index.

Configuration
REQ-031 SHALL, with SOFTPLUS_PERF_CNT_EN defined, increment perf_cnt[rsp_id] on each rsp_valid & rsp_ready, saturating at all-ones.
REQ-032 SHALL give cnt_clr priority over a simultaneous increment; the counter reads 0 on the following cycle.
REQ-033 SHALL, without SOFTPLUS_PERF_CNT_EN, keep the ports, tie perf_cnt to 0, ignore cnt_clr, and synthesise no counter flops.

Structure
REQ-034 SHALL place Q8.8 constants (DATA_W, FRAC_W=8) and the id-width function in shared package softplus_pkg.
REQ-035 SHALL instantiate the existing softplus core unchanged (operand in, out); a sub-module rr_arbiter (request vector, pointer -> one-hot grant) is natural.

Verification
REQ-036 SHALL check: req_valid[0]=1 with 0x0000 and rsp_ready=1 -> rsp_valid 2 cycles later, rsp_id=0, rsp_data equal to a standalone softplus core fed 0x0000.
REQ-037 SHALL check: all four requesters valid, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one response per cycle, rsp_id in the same sequence.
REQ-038 SHALL check: pipeline full, rsp_ready low for 5 cycles -> rsp_data/rsp_id stable, req_ready=0, both results delivered in order afterwards.
REQ-039 SHALL check: req_valid[3]=1 with 0xFB00 (-5.0) while req 1 issues 0x0500 (+5.0) -> rsp_id 1 then 3, each matching the core output.
REQ-040 SHALL check: rst_n pulsed low with both stages full -> rsp_valid and busy fall immediately, no response emerges, p=0 on release.
REQ-041 SHALL check, with SOFTPLUS_PERF_CNT_EN: three responses for requester 2 -> perf_cnt[2]=3; preloaded 0xFFFF stays 0xFFFF; cnt_clr -> 0.
